// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared jump-control encodings and PC alignment helpers
package cpu_pkg;

    typedef logic [1:0] jc_t;

    localparam jc_t JC_SEQ = 2'b00;
    localparam jc_t JC_JAL = 2'b01;
    localparam jc_t JC_JR  = 2'b10;
    localparam jc_t JC_BR  = 2'b11;

    localparam int DEFAULT_INSTR_BYTES = 4;
    localparam int DEFAULT_LSB         = $clog2(DEFAULT_INSTR_BYTES);

    function automatic int instr_lsb(input int instr_bytes);
        return $clog2(instr_bytes);
    endfunction

endpackage

// File: rtl/next_pc_unit_if.sv
// rtl/next_pc_unit_if.sv - fetch redirect bus between core control and the PC stage
interface next_pc_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              stall;
    jc_t               jump_ctrl;
    logic              branch_taken;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] branch_target;
    logic              exc_valid;
    logic [ADDR_W-1:0] exc_vector;
    logic [ADDR_W-1:0] pc;
    logic              redirect_pending;
    logic              redirect_taken;
    logic              misalign_fault;

    modport master (
        output stall, jump_ctrl, branch_taken, jump_target, jr_target,
               branch_target, exc_valid, exc_vector,
        input  pc, redirect_pending, redirect_taken, misalign_fault
    );

    modport slave (
        input  stall, jump_ctrl, branch_taken, jump_target, jr_target,
               branch_target, exc_valid, exc_vector,
        output pc, redirect_pending, redirect_taken, misalign_fault
    );
endinterface

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - priority select of the live redirect target plus force-alignment
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int INSTR_BYTES = 4
) (
    input  jc_t              i_jump_ctrl,
    input  logic             i_branch_taken,
    input  logic [ADDR_W-1:0] i_jump_target,
    input  logic [ADDR_W-1:0] i_jr_target,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic             i_exc_valid,
    input  logic [ADDR_W-1:0] i_exc_vector,
    output logic             o_req_valid,
    output logic [ADDR_W-1:0] o_req_target,
    output logic             o_req_misaligned,
    output logic             o_req_is_exc
);
    // Low-bit mask is all zeros when INSTR_BYTES==1, so no fault can ever be raised there.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);

    logic [ADDR_W-1:0] w_raw;

    always_comb begin
        o_req_valid  = 1'b0;
        o_req_is_exc = 1'b0;
        w_raw        = '0;
        if (i_exc_valid) begin
            o_req_valid  = 1'b1;
            o_req_is_exc = 1'b1;
            w_raw        = i_exc_vector;
        end else if (i_jump_ctrl == JC_JAL) begin
            o_req_valid = 1'b1;
            w_raw       = i_jump_target;
        end else if (i_jump_ctrl == JC_JR) begin
            o_req_valid = 1'b1;
            w_raw       = i_jr_target;
        end else if (i_jump_ctrl == JC_BR && i_branch_taken) begin
            o_req_valid = 1'b1;
            w_raw       = i_branch_target;
        end
    end

    assign o_req_target     = w_raw & ~LOW_MASK;
    assign o_req_misaligned = o_req_valid && !o_req_is_exc && ((w_raw & LOW_MASK) != '0);

endmodule

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - registered fetch PC with stall hold and a one-entry redirect buffer
module next_pc_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    next_pc_unit_if.slave   bus
);
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INSTR_BYTES);

    logic              w_req_valid;
    logic [ADDR_W-1:0] w_req_target;
    logic              w_req_misaligned;
    logic              w_req_is_exc;

    logic [ADDR_W-1:0] r_pc;
    logic              r_pending_valid;
    logic [ADDR_W-1:0] r_pending_target;
    logic              r_redirect_taken;
    logic              r_misalign_fault;

    next_pc_sel #(
        .ADDR_W      (ADDR_W),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_sel (
        .i_jump_ctrl      (bus.jump_ctrl),
        .i_branch_taken   (bus.branch_taken),
        .i_jump_target    (bus.jump_target),
        .i_jr_target      (bus.jr_target),
        .i_branch_target  (bus.branch_target),
        .i_exc_valid      (bus.exc_valid),
        .i_exc_vector     (bus.exc_vector),
        .o_req_valid      (w_req_valid),
        .o_req_target     (w_req_target),
        .o_req_misaligned (w_req_misaligned),
        .o_req_is_exc     (w_req_is_exc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc             <= RESET_PC;
            r_pending_valid  <= 1'b0;
            r_pending_target <= '0;
            r_redirect_taken <= 1'b0;
            r_misalign_fault <= 1'b0;
        end else begin
            r_redirect_taken <= 1'b0;
            r_misalign_fault <= 1'b0;
            if (!bus.stall) begin
                // A buffered redirect beats a same-cycle branch (wrong path), but never a trap.
                if (w_req_valid && w_req_is_exc) begin
                    r_pc             <= w_req_target;
                    r_pending_valid  <= 1'b0;
                    r_redirect_taken <= 1'b1;
                end else if (r_pending_valid) begin
                    r_pc             <= r_pending_target;
                    r_pending_valid  <= 1'b0;
                    r_redirect_taken <= 1'b1;
                end else if (w_req_valid) begin
                    r_pc             <= w_req_target;
                    r_redirect_taken <= 1'b1;
                    r_misalign_fault <= w_req_misaligned;
                end else begin
                    r_pc <= r_pc + PC_INC;
                end
            end else if (w_req_valid && (w_req_is_exc || !r_pending_valid)) begin
                r_pending_target <= w_req_target;
                r_pending_valid  <= 1'b1;
                r_misalign_fault <= w_req_misaligned;
            end
        end
    end

    assign bus.pc               = r_pc;
    assign bus.redirect_pending = r_pending_valid;
    assign bus.redirect_taken   = r_redirect_taken;
    assign bus.misalign_fault   = r_misalign_fault;

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - table-driven scoreboard bench for next_pc_unit
module tb_next_pc_unit;
    import cpu_pkg::*;

    typedef struct {
        logic        stall;
        jc_t         jc;
        logic        bt;
        logic [31:0] tgt;
        logic        exc;
        logic [31:0] ev;
        logic [31:0] exp_pc;
        logic        exp_pend;
        logic        exp_taken;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        taken;
        logic        fault;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    vec_t vecs[$];
    exp_t sb[$];

    next_pc_unit_if #(.ADDR_W(32)) bus ();

    next_pc_unit #(
        .ADDR_W      (32),
        .RESET_PC    (32'h0000_0000),
        .INSTR_BYTES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic s, input jc_t jc, input logic bt, input logic [31:0] tgt,
                       input logic exc, input logic [31:0] ev, input logic [31:0] epc,
                       input logic epend, input logic etk, input logic eflt);
        vec_t v;
        v.stall = s; v.jc = jc; v.bt = bt; v.tgt = tgt; v.exc = exc; v.ev = ev;
        v.exp_pc = epc; v.exp_pend = epend; v.exp_taken = etk; v.exp_fault = eflt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input exp_t e);
        n_vec++;
        if (bus.pc !== e.pc || bus.redirect_pending !== e.pend ||
            bus.redirect_taken !== e.taken || bus.misalign_fault !== e.fault) begin
            n_miss++;
            $display("FAIL %s: got pc=%h pend=%b tk=%b flt=%b, want pc=%h pend=%b tk=%b flt=%b",
                     name, bus.pc, bus.redirect_pending, bus.redirect_taken, bus.misalign_fault,
                     e.pc, e.pend, e.taken, e.fault);
        end
    endtask

    // Distinct targets per source so a wrong select is visible on pc.
    task automatic apply(input vec_t v);
        exp_t e;
        bus.stall         = v.stall;
        bus.jump_ctrl     = v.jc;
        bus.branch_taken  = v.bt;
        bus.jump_target   = (v.jc == JC_JAL) ? v.tgt : 32'hDEAD_0100;
        bus.jr_target     = (v.jc == JC_JR)  ? v.tgt : 32'hDEAD_0200;
        bus.branch_target = (v.jc == JC_BR)  ? v.tgt : 32'hDEAD_0300;
        bus.exc_valid     = v.exc;
        bus.exc_vector    = v.ev;
        e.pc = v.exp_pc; e.pend = v.exp_pend; e.taken = v.exp_taken; e.fault = v.exp_fault;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input vec_t v, input string name);
        exp_t e;
        apply(v);
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: scoreboard empty, got pc=%h want an entry", name, bus.pc);
        end else begin
            e = sb.pop_front();
            check(name, e);
        end
    endtask

    initial begin
        exp_t e;
        vec_t v;
        n_vec  = 0;
        n_miss = 0;
        bus.stall = 1'b0; bus.jump_ctrl = JC_SEQ; bus.branch_taken = 1'b0;
        bus.jump_target = '0; bus.jr_target = '0; bus.branch_target = '0;
        bus.exc_valid = 1'b0; bus.exc_vector = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e.pc = 32'h0; e.pend = 1'b0; e.taken = 1'b0; e.fault = 1'b0;
        check("reset", e);
        @(negedge clk);
        rst = 1'b1;

        //   stall jc      bt   target          exc  vector          pc              pend tk flt
        add(0, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_0004, 0, 0, 0);
        add(0, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_0008, 0, 0, 0);
        add(0, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_000C, 0, 0, 0);
        add(0, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_0010, 0, 0, 0);
        add(0, JC_JAL, 0, 32'h100,        0, 32'h0,         32'h0000_0100, 0, 1, 0);
        add(0, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_0104, 0, 0, 0);
        add(0, JC_BR,  0, 32'h200,        0, 32'h0,         32'h0000_0108, 0, 0, 0);
        add(0, JC_BR,  1, 32'h200,        0, 32'h0,         32'h0000_0200, 0, 1, 0);
        add(0, JC_JAL, 0, 32'h40,         0, 32'h0,         32'h0000_0040, 0, 1, 0);
        add(1, JC_JR,  0, 32'h80,         0, 32'h0,         32'h0000_0040, 1, 0, 0);
        add(1, JC_JAL, 0, 32'h90,         0, 32'h0,         32'h0000_0040, 1, 0, 0);
        add(1, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_0040, 1, 0, 0);
        add(0, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_0080, 0, 1, 0);
        add(0, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_0084, 0, 0, 0);
        add(1, JC_JR,  0, 32'h80,         0, 32'h0,         32'h0000_0084, 1, 0, 0);
        add(1, JC_SEQ, 0, 32'h0,          1, 32'h1000,      32'h0000_0084, 1, 0, 0);
        add(0, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_1000, 0, 1, 0);
        add(0, JC_JAL, 0, 32'h102,        0, 32'h0,         32'h0000_0100, 0, 1, 1);
        add(0, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_0104, 0, 0, 0);
        add(0, JC_JAL, 0, 32'hFFFF_FFFC,  0, 32'h0,         32'hFFFF_FFFC, 0, 1, 0);
        add(0, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_0000, 0, 0, 0);
        add(1, JC_JAL, 0, 32'h303,        0, 32'h0,         32'h0000_0000, 1, 0, 1);
        add(0, JC_JAL, 0, 32'h500,        0, 32'h0,         32'h0000_0300, 0, 1, 0);
        add(0, JC_SEQ, 0, 32'h0,          1, 32'h2002,      32'h0000_2000, 0, 1, 0);
        add(1, JC_JR,  0, 32'h600,        0, 32'h0,         32'h0000_2000, 1, 0, 0);
        add(0, JC_JR,  0, 32'h700,        1, 32'h3000,      32'h0000_3000, 0, 1, 0);
        add(0, JC_BR,  0, 32'h800,        0, 32'h0,         32'h0000_3004, 0, 0, 0);
        add(1, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_3004, 0, 0, 0);
        add(1, JC_BR,  0, 32'h900,        0, 32'h0,         32'h0000_3004, 0, 0, 0);
        add(0, JC_SEQ, 0, 32'h0,          0, 32'h0,         32'h0000_3008, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted mid-stall must discard the buffered redirect.
        v.stall = 1; v.jc = JC_JAL; v.bt = 0; v.tgt = 32'h700; v.exc = 0; v.ev = 32'h0;
        v.exp_pc = 32'h3008; v.exp_pend = 1; v.exp_taken = 0; v.exp_fault = 0;
        step(v, "midstall_latch");
        #2;
        rst = 1'b0;
        #1;
        e.pc = 32'h0; e.pend = 1'b0; e.taken = 1'b0; e.fault = 1'b0;
        check("async_reset", e);
        @(negedge clk);
        rst = 1'b1;
        v.stall = 0; v.jc = JC_SEQ; v.tgt = 32'h0;
        v.exp_pc = 32'h4; v.exp_pend = 0; v.exp_taken = 0; v.exp_fault = 0;
        step(v, "post_reset_seq");

        // Exception vector with low bits set: aligned but never faults, even under stall.
        v.stall = 1; v.jc = JC_SEQ; v.exc = 1; v.ev = 32'h5001;
        v.exp_pc = 32'h4; v.exp_pend = 1; v.exp_taken = 0; v.exp_fault = 0;
        step(v, "exc_stall_noflt");
        v.stall = 0; v.exc = 0; v.ev = 32'h0;
        v.exp_pc = 32'h5000; v.exp_pend = 0; v.exp_taken = 1; v.exp_fault = 0;
        step(v, "exc_release");

        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Registered program-counter stage for the pipelined CPU with an L1 I-cache. It replaces the purely combinational next-PC mux.
- Selects among sequential, JAL, JR/JALR, conditional-branch and exception targets.
- Holds the PC while fetch is stalled on a cache miss, and buffers one redirect that arrives during the stall.
- Width, reset vector and instruction size are parametrised. Misaligned targets are detected and force-aligned.

Parameters:
ADDR_W, 32, PC and target width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
INSTR_BYTES, 4, sequential increment; power of two, 1..8; alignment granule

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
stall  in  1  fetch/I-cache stall; PC must hold while 1
jump_ctrl  in  2  00 seq, 01 jal, 10 jr/jalr, 11 conditional branch
branch_taken  in  1  branch condition result; used only when jump_ctrl==11
jump_target  in  ADDR_W  JAL target
jr_target  in  ADDR_W  JR/JALR register target
branch_target  in  ADDR_W  branch target
exc_valid  in  1  exception/trap redirect request
exc_vector  in  ADDR_W  exception handler address
pc  out  ADDR_W  current fetch PC (registered)
redirect_pending  out  1  a buffered redirect is waiting for the stall to release
redirect_taken  out  1  1-cycle pulse: pc was loaded with a non-sequential value
misalign_fault  out  1  1-cycle pulse: an accepted target had nonzero low bits

Behaviour:
- Reset (rst==0, asynchronous): pc=RESET_PC; pending_valid=0; pending_target=0; redirect_taken=0; misalign_fault=0.
- Live request (combinational):
  - exc_valid -> exc_vector
  - else jump_ctrl==01 -> jump_target
  - else jump_ctrl==10 -> jr_target
  - else jump_ctrl==11 && branch_taken -> branch_target
  - else no request. This includes 00, and 11 with branch_taken==0.
- Alignment: let LSB = log2(INSTR_BYTES). An accepted target has bits [LSB-1:0] cleared. misalign_fault pulses the next cycle if those bits were nonzero. It never fires for exc_vector, and never when INSTR_BYTES==1.
- Cycle rule when stall==0 (all effects at the next clk edge):
  - pending_valid: pc<=pending_target; pending_valid<=0; redirect_taken<=1. A live non-exception request that cycle is dropped (wrong path). A live exception wins over pending and is loaded instead.
  - else live request: pc<=aligned target; redirect_taken<=1.
  - else: pc<=pc+INSTR_BYTES, wrapping modulo 2^ADDR_W; redirect_taken<=0.
- Cycle rule when stall==1:
  - pc holds; redirect_taken<=0.
  - Live request and !pending_valid: pending_target<=aligned target; pending_valid<=1.
  - Live non-exception request and pending_valid: dropped; the older redirect is kept.
  - Live exception: always overwrites pending_target and sets pending_valid.
- misalign_fault is evaluated when a request is latched or loaded, not when a pending entry is later applied. No double pulse.
- redirect_pending = pending_valid (registered).
- Latency: a redirect presented with stall==0 appears on pc after 1 edge. A redirect presented during a stall appears 1 edge after stall falls.
- Reset mid-stall discards any pending redirect.
- Wrap: pc=2^ADDR_W-INSTR_BYTES with no request -> 0. No fault is raised.

Decomposition:
- Shared package cpu_pkg:
  - JC_SEQ=2'b00, JC_JAL=2'b01, JC_JR=2'b10, JC_BR=2'b11
  - typedef for the jump_ctrl field
  - helper localparam for LSB = log2(INSTR_BYTES)
- One combinational sub-module next_pc_sel:
  - priority select plus alignment
  - outputs req_valid, req_target, req_misaligned, req_is_exc
- The top level holds the PC, pending buffer and pulse registers.

Test Plan:
- Reset then idle: rst low then high, jump_ctrl=00, stall=0 -> pc 0,4,8,C on successive edges; redirect_taken=0.
- JAL without stall: pc=0x10, jump_ctrl=01, jump_target=0x100 -> next pc=0x100, redirect_taken=1 for one cycle, then 0x104.
- Not-taken vs taken branch: jump_ctrl=11, branch_target=0x200, branch_taken=0 -> pc+4; branch_taken=1 -> pc=0x200.
- Redirect during stall:
  - stimulus: stall=1 for 3 cycles at pc=0x40; jr_target=0x80 in cycle 1; jump_target=0x90 in cycle 2
  - response: pc holds 0x40; redirect_pending=1; stall falls -> pc=0x80 (0x90 dropped); pending clears.
- Exception priority: stall=1 with pending 0x80, exc_valid with exc_vector=0x1000 -> after stall release, pc=0x1000.
- Misalign and wrap:
  - jump_target=0x102 -> pc=0x100, misalign_fault one-cycle pulse.
  - ADDR_W=32, pc=0xFFFF_FFFC with no request -> pc=0x0000_0000.
